// File: rtl/bus_translation_arb_if.sv
// Request-side and internal-bus signal bundle for bus_translation_arb.
// slave: the arbiter's view; master: requesters plus the internal bus responder.
interface bus_translation_arb_if #(
  parameter int pAHB_ADDR_WIDTH    = 32,
  parameter int pPAYLOAD_SIZE_BITS = 32,
  parameter int pNUM_CH            = 2
);
  logic [pNUM_CH-1:0]                    req_go;
  logic [pNUM_CH-1:0]                    req_rw;
  logic [pNUM_CH*pAHB_ADDR_WIDTH-1:0]    req_addr;
  logic [pNUM_CH*pPAYLOAD_SIZE_BITS-1:0] req_wdata;
  logic [pNUM_CH-1:0]                    req_done;
  logic [pNUM_CH-1:0]                    req_err;
  logic [pPAYLOAD_SIZE_BITS-1:0]         req_rdata;

  logic                                  I_go;
  logic [pAHB_ADDR_WIDTH-1:0]            I_int_addr;
  logic [pPAYLOAD_SIZE_BITS-1:0]         I_int_wdata;
  logic                                  I_int_write;
  logic                                  O_done;
  logic [pPAYLOAD_SIZE_BITS-1:0]         O_int_rdata;
  logic                                  O_int_rdata_valid;

  modport slave (
    input  req_go, req_rw, req_addr, req_wdata,
    input  O_done, O_int_rdata, O_int_rdata_valid,
    output req_done, req_err, req_rdata,
    output I_go, I_int_addr, I_int_wdata, I_int_write
  );

  modport master (
    output req_go, req_rw, req_addr, req_wdata,
    output O_done, O_int_rdata, O_int_rdata_valid,
    input  req_done, req_err, req_rdata,
    input  I_go, I_int_addr, I_int_wdata, I_int_write
  );
endinterface

// File: rtl/bus_translation_arb.sv
// Round-robin arbiter serialising pNUM_CH register requesters onto one I_go/O_done bus.
// Optional watchdog with error completion: define BUS_TRANS_TIMEOUT_EN.
module bus_translation_arb #(
  parameter int pAHB_ADDR_WIDTH    = 32,
  parameter int pPAYLOAD_SIZE_BITS = 32,
  parameter int pNUM_CH            = 2,
  parameter int pRD_DELAY          = 100,
  parameter int pTIMEOUT           = 1024,
  parameter int pCNT_WIDTH         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  bus_translation_arb_if.slave bus
);
  localparam int unsigned LP_N    = pNUM_CH;
  localparam int unsigned LP_CH_W = (pNUM_CH > 1) ? $clog2(pNUM_CH) : 1;
  localparam logic [pCNT_WIDTH-1:0] LP_RD_DELAY = pCNT_WIDTH'(pRD_DELAY);
`ifdef BUS_TRANS_TIMEOUT_EN
  localparam logic [pCNT_WIDTH-1:0] LP_TO_LAST = pCNT_WIDTH'(pTIMEOUT - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [pNUM_CH-1:0]            r_pending;
  logic [pNUM_CH-1:0]            r_done;
  logic [pNUM_CH-1:0]            w_clr;
  logic [pNUM_CH-1:0]            w_rot;
  logic [LP_CH_W-1:0]            r_rr;
  logic [LP_CH_W-1:0]            r_gnt;
  logic [LP_CH_W-1:0]            w_sel;
  logic [LP_CH_W-1:0]            w_rr_nxt;
  logic [LP_CH_W:0]              w_sum;
  logic                          w_found;
  logic                          w_fire;
  logic                          w_complete;
  logic                          w_rd_done;
  logic                          w_timeout;
  logic [pCNT_WIDTH-1:0]         r_cnt;
  logic                          r_valid_seen;
  logic                          r_go;
  logic                          r_write;
  logic                          w_rw_sel;
  logic [pAHB_ADDR_WIDTH-1:0]    r_addr;
  logic [pAHB_ADDR_WIDTH-1:0]    w_addr_sel;
  logic [pPAYLOAD_SIZE_BITS-1:0] r_wdata;
  logic [pPAYLOAD_SIZE_BITS-1:0] w_wdata_sel;
  logic [pPAYLOAD_SIZE_BITS-1:0] r_rdata;
  logic [pPAYLOAD_SIZE_BITS-1:0] r_cap;
  logic [pPAYLOAD_SIZE_BITS-1:0] w_rd_data;
`ifdef BUS_TRANS_TIMEOUT_EN
  logic [pNUM_CH-1:0]            r_err;
`endif

  // Rotate pending so bit 0 is the rr pointer; first set bit k maps back to (rr+k) mod N.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_sum   = '0;
    w_rot   = pNUM_CH'({r_pending, r_pending} >> r_rr);
    for (int unsigned i = 0; i < LP_N; i++) begin
      if (!w_found && w_rot[i]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, r_rr} + (LP_CH_W+1)'(i);
        if (w_sum >= (LP_CH_W+1)'(LP_N)) w_sum = w_sum - (LP_CH_W+1)'(LP_N);
        w_sel   = w_sum[LP_CH_W-1:0];
      end
    end
  end

  always_comb begin
    w_addr_sel  = '0;
    w_wdata_sel = '0;
    w_rw_sel    = 1'b0;
    for (int unsigned i = 0; i < LP_N; i++) begin
      if (w_sel == LP_CH_W'(i)) begin
        w_addr_sel  = bus.req_addr[i*pAHB_ADDR_WIDTH +: pAHB_ADDR_WIDTH];
        w_wdata_sel = bus.req_wdata[i*pPAYLOAD_SIZE_BITS +: pPAYLOAD_SIZE_BITS];
        w_rw_sel    = bus.req_rw[i];
      end
    end
  end

  assign w_clr     = w_fire ? (pNUM_CH'(1) << w_sel) : '0;
  assign w_rr_nxt  = (w_sel == LP_CH_W'(LP_N - 1)) ? '0 : w_sel + 1'b1;
  assign w_rd_data = bus.O_int_rdata_valid ? bus.O_int_rdata : r_cap;

  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    w_complete  = 1'b0;
    w_rd_done   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_fire      = 1'b1;
          w_state_nxt = w_rw_sel ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        if (bus.O_done) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
`ifdef BUS_TRANS_TIMEOUT_EN
        else if (r_cnt == LP_TO_LAST) begin
          w_timeout   = 1'b1;
          w_complete  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
`endif
      end
      ST_READ: begin
        if ((r_cnt >= LP_RD_DELAY) && (bus.O_int_rdata_valid || r_valid_seen)) begin
          w_rd_done   = 1'b1;
          w_complete  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
`ifdef BUS_TRANS_TIMEOUT_EN
        else if (r_cnt == LP_TO_LAST) begin
          w_timeout   = 1'b1;
          w_complete  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending    <= '0;
      r_rr         <= '0;
      r_gnt        <= '0;
      r_cnt        <= '0;
      r_valid_seen <= 1'b0;
      r_cap        <= '0;
      r_go         <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_done       <= '0;
`ifdef BUS_TRANS_TIMEOUT_EN
      r_err        <= '0;
`endif
    end else begin
      // A channel's own req_go in its completion cycle re-arms it: pending[g] is already clear.
      r_pending <= (r_pending | bus.req_go) & ~w_clr;
      r_go      <= w_fire;
      r_done    <= '0;
`ifdef BUS_TRANS_TIMEOUT_EN
      r_err     <= '0;
`endif
      if (w_fire) begin
        r_rr         <= w_rr_nxt;
        r_gnt        <= w_sel;
        r_addr       <= w_addr_sel;
        r_wdata      <= w_wdata_sel;
        r_write      <= w_rw_sel;
        r_cnt        <= '0;
        r_valid_seen <= 1'b0;
      end else if (r_state != ST_IDLE) begin
        if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
        if ((r_state == ST_READ) && bus.O_int_rdata_valid && (r_cnt < LP_RD_DELAY)) begin
          r_valid_seen <= 1'b1;
          r_cap        <= bus.O_int_rdata;
        end
        if (w_complete) begin
          r_done[r_gnt] <= 1'b1;
`ifdef BUS_TRANS_TIMEOUT_EN
          r_err[r_gnt]  <= w_timeout;
`endif
          r_valid_seen  <= 1'b0;
          r_write       <= 1'b0;
          r_addr        <= '0;
          r_wdata       <= '0;
        end
        if (w_rd_done) r_rdata <= w_rd_data;
      end
    end
  end

  assign bus.I_go        = r_go;
  assign bus.I_int_addr  = r_addr;
  assign bus.I_int_wdata = r_wdata;
  assign bus.I_int_write = r_write;
  assign bus.req_done    = r_done;
  assign bus.req_rdata   = r_rdata;
`ifdef BUS_TRANS_TIMEOUT_EN
  assign bus.req_err     = r_err;
`else
  assign bus.req_err     = '0;
`endif

endmodule

// File: tb/tb_bus_translation_arb.sv
// Directed bench for bus_translation_arb: 3 channels, pRD_DELAY=4, pTIMEOUT=16.
// Timeout scenario is compiled only when BUS_TRANS_TIMEOUT_EN is defined.
module tb_bus_translation_arb;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  bus_translation_arb_if #(
    .pAHB_ADDR_WIDTH(32), .pPAYLOAD_SIZE_BITS(32), .pNUM_CH(3)
  ) bus ();

  bus_translation_arb #(
    .pAHB_ADDR_WIDTH(32), .pPAYLOAD_SIZE_BITS(32), .pNUM_CH(3),
    .pRD_DELAY(4), .pTIMEOUT(16), .pCNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic rw, input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_rw[c]                = rw;
    bus.req_addr[c*32 +: 32]     = addr;
    bus.req_wdata[c*32 +: 32]    = wdata;
  endtask

  // Bounded wait for I_go; n = cycles waited. Callers check I_go afterwards.
  task automatic wait_go(output int n);
    n = 0;
    while (!bus.I_go && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_go = '0; bus.req_rw = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.O_done = 1'b0; bus.O_int_rdata = '0; bus.O_int_rdata_valid = 1'b0;
    tick(); tick();
    checks++; if (bus.I_go !== 1'b0) begin errors++; $display("FAIL reset_I_go: got %h expected 0", bus.I_go); end
    checks++; if (bus.I_int_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", bus.I_int_addr); end
    checks++; if (bus.I_int_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", bus.I_int_wdata); end
    checks++; if (bus.I_int_write !== 1'b0) begin errors++; $display("FAIL reset_write: got %h expected 0", bus.I_int_write); end
    checks++; if (bus.req_done !== 3'b000) begin errors++; $display("FAIL reset_done: got %b expected 000", bus.req_done); end
    checks++; if (bus.req_err !== 3'b000) begin errors++; $display("FAIL reset_err: got %b expected 000", bus.req_err); end
    checks++; if (bus.req_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus.req_rdata); end
    rst = 1'b0;
    tick();
    checks++; if (bus.I_go !== 1'b0) begin errors++; $display("FAIL reset_idle_go: got %h expected 0", bus.I_go); end
  endtask

  task automatic test_write();
    int n;
    set_ch(0, 1'b1, 32'h1000, 32'hDEADBEEF);
    bus.req_go = 3'b001; tick(); bus.req_go = 3'b000;
    wait_go(n);
    checks++; if (bus.I_go !== 1'b1) begin errors++; $display("FAIL write_go: got %h expected 1", bus.I_go); end
    checks++; if (n !== 1) begin errors++; $display("FAIL write_go_latency: got %0d expected 1", n); end
    checks++; if (bus.I_int_addr !== 32'h1000) begin errors++; $display("FAIL write_addr: got %h expected 00001000", bus.I_int_addr); end
    checks++; if (bus.I_int_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL write_wdata: got %h expected deadbeef", bus.I_int_wdata); end
    checks++; if (bus.I_int_write !== 1'b1) begin errors++; $display("FAIL write_dir: got %h expected 1", bus.I_int_write); end
    tick();
    checks++; if (bus.I_go !== 1'b0) begin errors++; $display("FAIL write_go_single: got %h expected 0", bus.I_go); end
    tick(); tick();
    checks++; if (bus.req_done !== 3'b000) begin errors++; $display("FAIL write_done_early: got %b expected 000", bus.req_done); end
    bus.O_done = 1'b1; tick(); bus.O_done = 1'b0;
    checks++; if (bus.req_done !== 3'b001) begin errors++; $display("FAIL write_done: got %b expected 001", bus.req_done); end
    checks++; if (bus.req_err !== 3'b000) begin errors++; $display("FAIL write_err: got %b expected 000", bus.req_err); end
    checks++; if (bus.I_int_addr !== 32'h0) begin errors++; $display("FAIL write_addr_clear: got %h expected 0", bus.I_int_addr); end
    checks++; if (bus.I_go !== 1'b0) begin errors++; $display("FAIL write_go_after: got %h expected 0", bus.I_go); end
    tick();
    checks++; if (bus.req_done !== 3'b000) begin errors++; $display("FAIL write_done_pulse: got %b expected 000", bus.req_done); end
  endtask

  task automatic test_read();
    int n;
    set_ch(1, 1'b0, 32'h2004, 32'h0);
    bus.req_go = 3'b010; tick(); bus.req_go = 3'b000;
    wait_go(n);
    checks++; if (bus.I_go !== 1'b1 || n !== 1) begin errors++; $display("FAIL read_go: got go=%h n=%0d expected go=1 n=1", bus.I_go, n); end
    checks++; if (bus.I_int_addr !== 32'h2004) begin errors++; $display("FAIL read_addr: got %h expected 00002004", bus.I_int_addr); end
    checks++; if (bus.I_int_write !== 1'b0) begin errors++; $display("FAIL read_dir: got %h expected 0", bus.I_int_write); end
    tick();
    bus.O_int_rdata = 32'hCAFEF00D; bus.O_int_rdata_valid = 1'b1;
    tick();
    bus.O_int_rdata = 32'h11111111; bus.O_int_rdata_valid = 1'b0;
    checks++; if (bus.req_done !== 3'b000) begin errors++; $display("FAIL read_done_early: got %b expected 000", bus.req_done); end
    tick(); tick();
    checks++; if (bus.req_done !== 3'b000) begin errors++; $display("FAIL read_done_cnt4: got %b expected 000", bus.req_done); end
    tick();
    checks++; if (bus.req_done !== 3'b010) begin errors++; $display("FAIL read_done: got %b expected 010", bus.req_done); end
    checks++; if (bus.req_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL read_rdata: got %h expected cafef00d", bus.req_rdata); end
    checks++; if (bus.req_err !== 3'b000) begin errors++; $display("FAIL read_err: got %b expected 000", bus.req_err); end
    tick();
    checks++; if (bus.req_done !== 3'b000 || bus.req_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL read_hold: got done=%b rdata=%h expected 000 cafef00d", bus.req_done, bus.req_rdata); end

    // Valid arrives exactly when counter reaches the delay: live data is taken.
    set_ch(2, 1'b0, 32'h3008, 32'h0);
    bus.req_go = 3'b100; tick(); bus.req_go = 3'b000;
    wait_go(n);
    checks++; if (bus.I_go !== 1'b1) begin errors++; $display("FAIL read2_go: got %h expected 1", bus.I_go); end
    tick(); tick(); tick(); tick();
    checks++; if (bus.req_done !== 3'b000) begin errors++; $display("FAIL read2_wait: got %b expected 000", bus.req_done); end
    bus.O_int_rdata = 32'h12345678; bus.O_int_rdata_valid = 1'b1;
    tick();
    bus.O_int_rdata_valid = 1'b0;
    checks++; if (bus.req_done !== 3'b100) begin errors++; $display("FAIL read2_done: got %b expected 100", bus.req_done); end
    checks++; if (bus.req_rdata !== 32'h12345678) begin errors++; $display("FAIL read2_rdata: got %h expected 12345678", bus.req_rdata); end
  endtask

  task automatic test_arbitration();
    int n;
    int ord1[3] = '{0, 1, 2};
    int ord2[3] = '{2, 0, 1};
    logic [2:0] exp_done;
    set_ch(0, 1'b1, 32'h100, 32'hA0);
    set_ch(1, 1'b1, 32'h200, 32'hA1);
    set_ch(2, 1'b1, 32'h300, 32'hA2);
    for (int r = 0; r < 3; r++) begin
      if (r == 0)      bus.req_go = 3'b111;
      else if (r == 1) bus.req_go = 3'b010;
      else             bus.req_go = 3'b111;
      tick(); bus.req_go = 3'b000;
      for (int k = 0; k < ((r == 1) ? 1 : 3); k++) begin
        int e;
        e = (r == 0) ? ord1[k] : ((r == 1) ? 1 : ord2[k]);
        wait_go(n);
        checks++; if (bus.I_go !== 1'b1) begin errors++; $display("FAIL arb_go r%0d k%0d: got %h expected 1", r, k, bus.I_go); end
        checks++; if (bus.I_int_addr !== 32'(32'h100 * (e + 1))) begin errors++; $display("FAIL arb_order r%0d k%0d: got addr %h expected channel %0d", r, k, bus.I_int_addr, e); end
        tick();
        bus.O_done = 1'b1; tick(); bus.O_done = 1'b0;
        exp_done = 3'b001 << e;
        checks++; if (bus.req_done !== exp_done) begin errors++; $display("FAIL arb_done r%0d k%0d: got %b expected %b", r, k, bus.req_done, exp_done); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    set_ch(0, 1'b0, 32'h4000, 32'h0);
    bus.req_go = 3'b001; tick(); bus.req_go = 3'b000;
    wait_go(n);
    checks++; if (bus.I_go !== 1'b1) begin errors++; $display("FAIL rstmid_go: got %h expected 1", bus.I_go); end
    set_ch(2, 1'b1, 32'h5000, 32'h55);
    bus.req_go = 3'b100; tick(); bus.req_go = 3'b000;
    tick();
    rst = 1'b1; tick();
    checks++; if (bus.I_go !== 1'b0 || bus.I_int_addr !== 32'h0 || bus.I_int_write !== 1'b0) begin errors++; $display("FAIL rstmid_bus: got go=%h addr=%h wr=%h expected 0 0 0", bus.I_go, bus.I_int_addr, bus.I_int_write); end
    checks++; if (bus.req_done !== 3'b000 || bus.req_rdata !== 32'h0) begin errors++; $display("FAIL rstmid_req: got done=%b rdata=%h expected 000 0", bus.req_done, bus.req_rdata); end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (bus.I_go !== 1'b0 || bus.req_done !== 3'b000) begin errors++; $display("FAIL rstmid_quiet %0d: got go=%h done=%b expected 0 000", i, bus.I_go, bus.req_done); end
    end
    bus.req_go = 3'b100; tick(); bus.req_go = 3'b000;
    wait_go(n);
    checks++; if (bus.I_go !== 1'b1 || n !== 1) begin errors++; $display("FAIL rstmid_post_go: got go=%h n=%0d expected 1 1", bus.I_go, n); end
    checks++; if (bus.I_int_addr !== 32'h5000) begin errors++; $display("FAIL rstmid_post_addr: got %h expected 00005000", bus.I_int_addr); end
    tick();
    bus.O_done = 1'b1; tick(); bus.O_done = 1'b0;
    checks++; if (bus.req_done !== 3'b100 || bus.req_err !== 3'b000) begin errors++; $display("FAIL rstmid_post_done: got done=%b err=%b expected 100 000", bus.req_done, bus.req_err); end
  endtask

  task automatic test_rerequest();
    int n;
    set_ch(0, 1'b1, 32'h6000, 32'h66);
    bus.req_go = 3'b001; tick(); bus.req_go = 3'b000;
    wait_go(n);
    checks++; if (bus.I_go !== 1'b1) begin errors++; $display("FAIL rereq_go1: got %h expected 1", bus.I_go); end
    tick();
    bus.O_done = 1'b1; bus.req_go = 3'b001;
    tick();
    bus.O_done = 1'b0; bus.req_go = 3'b000;
    checks++; if (bus.req_done !== 3'b001) begin errors++; $display("FAIL rereq_done1: got %b expected 001", bus.req_done); end
    tick();
    checks++; if (bus.I_go !== 1'b1 || bus.I_int_addr !== 32'h6000) begin errors++; $display("FAIL rereq_go2: got go=%h addr=%h expected 1 00006000", bus.I_go, bus.I_int_addr); end
    tick();
    bus.O_done = 1'b1; tick(); bus.O_done = 1'b0;
    checks++; if (bus.req_done !== 3'b001) begin errors++; $display("FAIL rereq_done2: got %b expected 001", bus.req_done); end
    tick();
    checks++; if (bus.I_go !== 1'b0 || bus.req_done !== 3'b000) begin errors++; $display("FAIL rereq_extra: got go=%h done=%b expected 0 000", bus.I_go, bus.req_done); end
  endtask

`ifdef BUS_TRANS_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    set_ch(1, 1'b1, 32'h7000, 32'h77);
    bus.req_go = 3'b010; tick(); bus.req_go = 3'b000;
    wait_go(n);
    checks++; if (bus.I_go !== 1'b1) begin errors++; $display("FAIL to_wr_go: got %h expected 1", bus.I_go); end
    for (int i = 1; i < 16; i++) begin
      tick();
      checks++; if (bus.req_done !== 3'b000) begin errors++; $display("FAIL to_wr_early cycle %0d: got %b expected 000", i, bus.req_done); end
    end
    tick();
    checks++; if (bus.req_done !== 3'b010 || bus.req_err !== 3'b010) begin errors++; $display("FAIL to_wr_done: got done=%b err=%b expected 010 010", bus.req_done, bus.req_err); end
    checks++; if (bus.I_int_addr !== 32'h0) begin errors++; $display("FAIL to_wr_clear: got %h expected 0", bus.I_int_addr); end

    set_ch(2, 1'b0, 32'h7008, 32'h0);
    bus.req_go = 3'b100; tick(); bus.req_go = 3'b000;
    wait_go(n);
    for (int i = 0; i < 16; i++) tick();
    checks++; if (bus.req_done !== 3'b100 || bus.req_err !== 3'b100) begin errors++; $display("FAIL to_rd_done: got done=%b err=%b expected 100 100", bus.req_done, bus.req_err); end
    checks++; if (bus.req_rdata !== 32'h0) begin errors++; $display("FAIL to_rd_rdata: got %h expected 0", bus.req_rdata); end

    set_ch(0, 1'b1, 32'h7010, 32'h70);
    bus.req_go = 3'b001; tick(); bus.req_go = 3'b000;
    wait_go(n);
    tick();
    bus.O_done = 1'b1; tick(); bus.O_done = 1'b0;
    checks++; if (bus.req_done !== 3'b001 || bus.req_err !== 3'b000) begin errors++; $display("FAIL to_next: got done=%b err=%b expected 001 000", bus.req_done, bus.req_err); end
  endtask
`else
  task automatic test_no_timeout();
    int n;
    set_ch(1, 1'b1, 32'h7000, 32'h77);
    bus.req_go = 3'b010; tick(); bus.req_go = 3'b000;
    wait_go(n);
    checks++; if (bus.I_go !== 1'b1) begin errors++; $display("FAIL nto_go: got %h expected 1", bus.I_go); end
    for (int i = 0; i < 24; i++) tick();
    checks++; if (bus.req_done !== 3'b000) begin errors++; $display("FAIL nto_wait: got %b expected 000", bus.req_done); end
    bus.O_done = 1'b1; tick(); bus.O_done = 1'b0;
    checks++; if (bus.req_done !== 3'b010 || bus.req_err !== 3'b000) begin errors++; $display("FAIL nto_done: got done=%b err=%b expected 010 000", bus.req_done, bus.req_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_arbitration();
    test_reset_mid();
    test_rerequest();
`ifdef BUS_TRANS_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
